// File: rtl/md_sched.sv
// -----------------------------------------------------------------------------
// md_sched -- multiply/divide scheduler for the pipelined MIPS core (E stage).
//
// Accepts mult/multu/div/divu/mthi/mtlo from the E stage. Multi-cycle ops
// compute their result at issue into shadow registers, then hold the unit
// busy for a fixed number of cycles before committing the shadows to HI/LO.
// A stall toward D is raised while an MD-class instruction would collide.
//
// Parameters
//   MULT_CYCLES  busy cycles for mult/multu (1..15)
//   DIV_CYCLES   busy cycles for div/divu   (1..15)
// Ports
//   clk       in   system clock, rising edge
//   reset     in   asynchronous active-high reset, clears all state
//   start     in   E-stage issue strobe, qualified by MDOp
//   MDOp      in   0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo,
//                  7 reserved (none)
//   A, B      in   forwarded rs/rt operands
//   D_md      in   instruction in D is MD-class
//   busy      out  multi-cycle operation in progress
//   HI, LO    out  architectural HI/LO
//   md_stall  out  stall request to D/F
// -----------------------------------------------------------------------------
module md_sched #(
   parameter int MULT_CYCLES = 5,
   parameter int DIV_CYCLES  = 10
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic [2:0]  MDOp,
   input  logic [31:0] A,
   input  logic [31:0] B,
   input  logic        D_md,
   output logic        busy,
   output logic [31:0] HI,
   output logic [31:0] LO,
   output logic        md_stall
);

   localparam logic [0:0] S_IDLE = 1'b0;
   localparam logic [0:0] S_RUN  = 1'b1;

   localparam logic [2:0] OP_MULT  = 3'd1;
   localparam logic [2:0] OP_MULTU = 3'd2;
   localparam logic [2:0] OP_DIV   = 3'd3;
   localparam logic [2:0] OP_DIVU  = 3'd4;
   localparam logic [2:0] OP_MTHI  = 3'd5;
   localparam logic [2:0] OP_MTLO  = 3'd6;

   localparam logic [3:0] MULT_N = 4'(MULT_CYCLES);
   localparam logic [3:0] DIV_N  = 4'(DIV_CYCLES);

   logic [0:0]  state_q, state_d;
   logic [3:0]  cnt_q, cnt_d;
   logic [31:0] hi_q, hi_d;
   logic [31:0] lo_q, lo_d;
   logic [31:0] hi_n_q, hi_n_d;
   logic [31:0] lo_n_q, lo_n_d;
   logic        dz_q, dz_d;

   // ---------------------------------------------------------------------------
   // Arithmetic (evaluated on the issue cycle operands)
   // ---------------------------------------------------------------------------
   logic signed [31:0] a_s;
   logic signed [31:0] b_div_s;
   logic signed [63:0] prod_s;
   logic        [63:0] prod_u;
   logic signed [31:0] quo_s;
   logic signed [31:0] rem_s;
   logic        [31:0] b_div_u;
   logic        [31:0] quo_u;
   logic        [31:0] rem_u;
   logic               b_zero;
   logic               div_ovf;

   assign a_s     = $signed(A);
   assign b_zero  = (B == 32'd0);
   assign div_ovf = (A == 32'h8000_0000) && (B == 32'hFFFF_FFFF);

   assign prod_s = 64'(a_s) * 64'($signed(B));
   assign prod_u = {32'd0, A} * {32'd0, B};

   // The divisor is replaced by 1 when B==0 (result discarded anyway) and for
   // the -2^31 / -1 overflow: dividing by 1 yields exactly the required
   // quotient 0x80000000 with remainder 0, and no undefined division occurs.
   assign b_div_s = (b_zero || div_ovf) ? 32'sd1 : $signed(B);
   assign b_div_u = b_zero ? 32'd1 : B;

   assign quo_s = a_s / b_div_s;
   assign rem_s = a_s % b_div_s;
   assign quo_u = A / b_div_u;
   assign rem_u = A % b_div_u;

   // ---------------------------------------------------------------------------
   // Next-state logic
   // ---------------------------------------------------------------------------
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      hi_d    = hi_q;
      lo_d    = lo_q;
      hi_n_d  = hi_n_q;
      lo_n_d  = lo_n_q;
      dz_d    = dz_q;

      if (state_q == S_IDLE) begin
         if (start) begin
            case (MDOp)
               OP_MULT: begin
                  hi_n_d  = prod_s[63:32];
                  lo_n_d  = prod_s[31:0];
                  dz_d    = 1'b0;
                  cnt_d   = MULT_N;
                  state_d = S_RUN;
               end
               OP_MULTU: begin
                  hi_n_d  = prod_u[63:32];
                  lo_n_d  = prod_u[31:0];
                  dz_d    = 1'b0;
                  cnt_d   = MULT_N;
                  state_d = S_RUN;
               end
               OP_DIV: begin
                  hi_n_d  = rem_s;
                  lo_n_d  = quo_s;
                  dz_d    = b_zero;
                  cnt_d   = DIV_N;
                  state_d = S_RUN;
               end
               OP_DIVU: begin
                  hi_n_d  = rem_u;
                  lo_n_d  = quo_u;
                  dz_d    = b_zero;
                  cnt_d   = DIV_N;
                  state_d = S_RUN;
               end
               OP_MTHI: hi_d = A;
               OP_MTLO: lo_d = A;
               default: ;
            endcase
         end
      end else begin
         // Any start seen here is illegal and deliberately ignored.
         cnt_d = cnt_q - 4'd1;
         if (cnt_q == 4'd1) begin
            state_d = S_IDLE;
            // Divide by zero keeps HI/LO: the shadows are simply not committed.
            if (!dz_q) begin
               hi_d = hi_n_q;
               lo_d = lo_n_q;
            end
         end
      end
   end

   // ---------------------------------------------------------------------------
   // State registers
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= S_IDLE;
         cnt_q   <= 4'd0;
         hi_q    <= 32'd0;
         lo_q    <= 32'd0;
         hi_n_q  <= 32'd0;
         lo_n_q  <= 32'd0;
         dz_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         hi_q    <= hi_d;
         lo_q    <= lo_d;
         hi_n_q  <= hi_n_d;
         lo_n_q  <= lo_n_d;
         dz_q    <= dz_d;
      end
   end

   // ---------------------------------------------------------------------------
   // Outputs
   // ---------------------------------------------------------------------------
   assign busy = (state_q == S_RUN);
   assign HI   = hi_q;
   assign LO   = lo_q;
   // start is included because busy only rises one cycle after issue.
   assign md_stall = D_md & (start | busy);

endmodule

// File: tb/tb_md_sched.sv
// -----------------------------------------------------------------------------
// tb_md_sched -- self-checking bench for md_sched.
// Table-driven directed vectors, hand-written multi-cycle sequences (stall,
// ignored issue while busy, asynchronous reset mid-operation) and a randomized
// phase compared each cycle against a behavioural model.
// -----------------------------------------------------------------------------
module tb_md_sched;

   logic        clk = 1'b0;
   logic        reset;
   logic        start;
   logic [2:0]  MDOp;
   logic [31:0] A;
   logic [31:0] B;
   logic        D_md;
   logic        busy;
   logic [31:0] HI;
   logic [31:0] LO;
   logic        md_stall;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   md_sched #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
      .clk     (clk),
      .reset   (reset),
      .start   (start),
      .MDOp    (MDOp),
      .A       (A),
      .B       (B),
      .D_md    (D_md),
      .busy    (busy),
      .HI      (HI),
      .LO      (LO),
      .md_stall(md_stall)
   );

   typedef struct {
      logic [2:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] hi;
      logic [31:0] lo;
      int          cyc;
   } vec_t;

   vec_t tbl[14];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Reference results straight from the architectural definition, using
   // 64-bit integer arithmetic (no overflow special case needed there).
   function automatic void model_op(input logic [2:0] op, input logic [31:0] a,
                                    input logic [31:0] b, output logic [31:0] hi,
                                    output logic [31:0] lo, output bit ok);
      longint      sa, sb, q, r;
      logic [63:0] p;
      sa = $signed(a);
      sb = $signed(b);
      p  = 64'd0;
      ok = 1'b1;
      case (op)
         3'd1: p = sa * sb;
         3'd2: p = {32'd0, a} * {32'd0, b};
         3'd3: if (b == 32'd0) ok = 1'b0;
               else begin
                  q = sa / sb;
                  r = sa % sb;
                  p = {r[31:0], q[31:0]};
               end
         3'd4: if (b == 32'd0) ok = 1'b0;
               else p = {a % b, a / b};
         default: ok = 1'b0;
      endcase
      hi = p[63:32];
      lo = p[31:0];
   endfunction

   function automatic logic [31:0] pick();
      case ($urandom_range(0, 5))
         0: return 32'd0;
         1: return 32'hFFFF_FFFF;
         2: return 32'h8000_0000;
         3: return 32'($urandom_range(0, 20));
         default: return $urandom;
      endcase
   endfunction

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] cur_hi, cur_lo;
      logic [31:0] m_hi, m_lo, m_phi, m_plo, r_hi, r_lo;
      bit          m_commit, ok, hold;
      int          m_left, n;

      tbl[0]  = '{3'd1, 32'hFFFF_FFFE, 32'd3,        32'hFFFF_FFFF, 32'hFFFF_FFFA, 5};
      tbl[1]  = '{3'd2, 32'hFFFF_FFFF, 32'd2,        32'h0000_0001, 32'hFFFF_FFFE, 5};
      tbl[2]  = '{3'd4, 32'd7,         32'd2,        32'h0000_0001, 32'h0000_0003, 10};
      tbl[3]  = '{3'd3, 32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFF, 32'hFFFF_FFFD, 10};
      tbl[4]  = '{3'd3, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 10};
      tbl[5]  = '{3'd5, 32'h0000_0011, 32'd9,        32'h0000_0011, 32'h8000_0000, 0};
      tbl[6]  = '{3'd6, 32'h0000_0022, 32'd9,        32'h0000_0011, 32'h0000_0022, 0};
      tbl[7]  = '{3'd3, 32'd5,         32'd0,        32'h0000_0011, 32'h0000_0022, 10};
      tbl[8]  = '{3'd4, 32'd9,         32'd0,        32'h0000_0011, 32'h0000_0022, 10};
      tbl[9]  = '{3'd0, 32'h0000_0099, 32'd1,        32'h0000_0011, 32'h0000_0022, 0};
      tbl[10] = '{3'd7, 32'h0000_0077, 32'd1,        32'h0000_0011, 32'h0000_0022, 0};
      tbl[11] = '{3'd1, 32'd7,         32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 5};
      tbl[12] = '{3'd3, 32'd7,         32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD, 10};
      tbl[13] = '{3'd2, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000, 5};

      // Reset state
      reset = 1'b1; start = 1'b0; MDOp = 3'd0; A = 32'd0; B = 32'd0; D_md = 1'b0;
      tick();
      tick();
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_hi", HI, 32'd0);
      chk("rst_lo", LO, 32'd0);
      chk("rst_stall_idle", 32'(md_stall), 32'd0);
      D_md = 1'b1; start = 1'b1;
      #1;
      chk("rst_stall_comb", 32'(md_stall), 32'd1);
      tick();
      D_md = 1'b0; start = 1'b0; reset = 1'b0;
      tick();

      // Table-driven vectors, each issued in the first cycle busy is low
      cur_hi = 32'd0;
      cur_lo = 32'd0;
      for (int i = 0; i < 14; i++) begin
         start = 1'b1; MDOp = tbl[i].op; A = tbl[i].a; B = tbl[i].b;
         tick();
         start = 1'b0; MDOp = 3'd0; A = $urandom; B = $urandom;
         #1;
         n = 0;
         hold = 1'b1;
         while (busy === 1'b1 && n < 20) begin
            if (HI !== cur_hi || LO !== cur_lo) hold = 1'b0;
            n++;
            tick();
            #1;
         end
         chk($sformatf("v%0d_busy_len", i), 32'(n), 32'(tbl[i].cyc));
         chk($sformatf("v%0d_hold", i), 32'(hold), 32'd1);
         chk($sformatf("v%0d_hi", i), HI, tbl[i].hi);
         chk($sformatf("v%0d_lo", i), LO, tbl[i].lo);
         cur_hi = tbl[i].hi;
         cur_lo = tbl[i].lo;
      end

      // Stall held across a mult, with illegal issues attempted while busy
      tick();
      D_md = 1'b1;
      start = 1'b1; MDOp = 3'd1; A = 32'd2; B = 32'd3;
      #1;
      chk("stall_issue", 32'(md_stall), 32'd1);
      tick();
      hold = 1'b1;
      for (int k = 1; k <= 5; k++) begin
         start = (k == 2 || k == 3);
         MDOp  = (k == 2) ? 3'd6 : 3'd1;
         A     = (k == 2) ? 32'h55 : 32'd100;
         B     = 32'd100;
         #1;
         if (md_stall !== 1'b1 || busy !== 1'b1) hold = 1'b0;
         if (HI !== cur_hi || LO !== cur_lo) hold = 1'b0;
         tick();
      end
      start = 1'b0; MDOp = 3'd0;
      #1;
      chk("stall_busy_window", 32'(hold), 32'd1);
      chk("stall_end", 32'(md_stall), 32'd0);
      chk("ignore_busy", 32'(busy), 32'd0);
      chk("ignore_hi", HI, 32'd0);
      chk("ignore_lo", LO, 32'd6);
      D_md = 1'b0;

      // Asynchronous reset in the middle of a div
      tick();
      start = 1'b1; MDOp = 3'd3; A = 32'd100; B = 32'd7;
      tick();
      start = 1'b0; MDOp = 3'd0;
      tick();
      tick();
      tick();
      #2;
      chk("pre_rst_busy", 32'(busy), 32'd1);
      reset = 1'b1;
      #1;
      chk("async_rst_busy", 32'(busy), 32'd0);
      chk("async_rst_hi", HI, 32'd0);
      chk("async_rst_lo", LO, 32'd0);
      tick();
      reset = 1'b0;
      tick();
      start = 1'b1; MDOp = 3'd1; A = 32'd3; B = 32'd3;
      tick();
      start = 1'b0; MDOp = 3'd0;
      #1;
      n = 0;
      while (busy === 1'b1 && n < 20) begin
         n++;
         tick();
         #1;
      end
      chk("post_rst_len", 32'(n), 32'd5);
      chk("post_rst_hi", HI, 32'd0);
      chk("post_rst_lo", LO, 32'd9);

      // Randomized phase against the behavioural model
      tick();
      m_hi = 32'd0; m_lo = 32'd9; m_phi = 32'd0; m_plo = 32'd0;
      m_left = 0; m_commit = 1'b0;
      for (int c = 0; c < 400; c++) begin
         start = ($urandom_range(0, 2) != 0);
         MDOp  = 3'($urandom_range(0, 7));
         A     = pick();
         B     = pick();
         D_md  = 1'($urandom_range(0, 1));
         #1;
         chk("r_busy", 32'(busy), 32'(m_left > 0));
         chk("r_hi", HI, m_hi);
         chk("r_lo", LO, m_lo);
         chk("r_stall", 32'(md_stall), 32'(D_md && (start || m_left > 0)));
         if (m_left > 0) begin
            m_left--;
            if (m_left == 0 && m_commit) begin
               m_hi = m_phi;
               m_lo = m_plo;
            end
         end else if (start) begin
            if (MDOp >= 3'd1 && MDOp <= 3'd4) begin
               model_op(MDOp, A, B, r_hi, r_lo, ok);
               m_phi    = r_hi;
               m_plo    = r_lo;
               m_commit = ok;
               m_left   = (MDOp <= 3'd2) ? 5 : 10;
            end else if (MDOp == 3'd5) begin
               m_hi = A;
            end else if (MDOp == 3'd6) begin
               m_lo = A;
            end
         end
         tick();
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/md_sched.md
# md_sched

Multiply/divide unit scheduler for the pipelined MIPS core. Accepts mult/multu/div/divu/mthi/mtlo issued from the E stage and runs multi-cycle operations with a down-counter. It owns the HI/LO registers and raises a stall toward the D stage, so any MD-class instruction waits while the unit is occupied. It sits beside the ALU in the E stage; mfhi/mflo read HI/LO directly.

## Interface
- MULT_CYCLES, 5, busy cycles for mult/multu (1..15)
- DIV_CYCLES, 10, busy cycles for div/divu (1..15)
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high; clears all state
- start  in  1  E-stage issue strobe, qualified by MDOp; one cycle per instruction
- MDOp  in  3  0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo, 7 reserved (treated as none)
- A  in  32  forwarded rs value in E
- B  in  32  forwarded rt value in E
- D_md  in  1  instruction in D is MD-class (mult/div/mfhi/mflo/mthi/mtlo)
- busy  out  1  operation in progress
- HI  out  32  architectural HI
- LO  out  32  architectural LO
- md_stall  out  1  stall request to D/F, = D_md & (start | busy)

## Operation
- States: IDLE, RUN.
- IDLE with start and MDOp in {1..4}:
  - Latch the result into shadow registers hi_n/lo_n.
  - Load cnt with MULT_CYCLES or DIV_CYCLES and go to RUN.
- RUN: cnt decrements every cycle. On the edge where cnt==1, copy hi_n/lo_n into HI/LO, then go to IDLE.
- busy = (state==RUN).
- Arithmetic:
  - mult: {HI,LO} = $signed(A)*$signed(B), 64-bit.
  - multu: {HI,LO} = A*B, unsigned 64-bit.
  - div: LO = signed quotient truncated toward zero; HI = remainder with the sign of the dividend.
  - divu: LO = A/B, HI = A%B, unsigned.
  - div with A=0x80000000, B=0xFFFFFFFF: LO=0x80000000, HI=0.
- Divide by zero (B==0, div or divu):
  - The full DIV_CYCLES busy period still runs.
  - HI/LO stay unchanged at completion (shadow not committed).
- mthi/mtlo in IDLE with start: on the next edge, HI (or LO) = A; no busy; the other register is untouched.
- start while busy (any MDOp) is ignored. This is illegal under correct stalling; the bench checks that no state changes.
- start with MDOp 0 or 7 is a no-op.
- md_stall depends only on the current-cycle inputs and state. It covers the issue cycle (start) because busy is not yet visible there.

## Timing
- Reset values: state=IDLE, cnt=0, busy=0, HI=0, LO=0, shadows=0, md_stall=D_md&start (combinational; 0 when inputs are low).
- Reset asserted mid-operation: the operation is abandoned, HI/LO=0, and busy drops immediately (asynchronous).
- Issue edge at cycle t, busy timing:
  - busy=1 during cycles t+1 .. t+N, with N = MULT_CYCLES or DIV_CYCLES.
  - HI/LO show the new value from cycle t+N+1, the same cycle busy=0.
- mthi/mtlo issued at cycle t: HI/LO show the new value from cycle t+1.
- Back-to-back issue: a new start is accepted in the first cycle busy=0. The pipeline guarantees the gap through md_stall.
- mfhi in D stalls until busy falls, then reads the committed value in E via HI/LO (no bypass of in-flight results).
- cnt is 4 bits. Parameters above 15 are illegal; the block does not check them.

## Test plan
- mult: A=0xFFFFFFFE (-2), B=3, start at t:
  - busy high t+1..t+5.
  - HI=0xFFFFFFFF, LO=0xFFFFFFFA at t+6.
  - HI/LO unchanged during t+1..t+5.
- multu then divu:
  - multu with A=0xFFFFFFFF, B=2 gives HI=1, LO=0xFFFFFFFE.
  - divu issued at t+6 with A=7, B=2: busy t+7..t+16, then LO=3, HI=1.
- Signed div and overflow case:
  - div with A=-7, B=2 gives LO=0xFFFFFFFD, HI=0xFFFFFFFF.
  - div with A=0x80000000, B=-1 gives LO=0x80000000, HI=0.
- Divide by zero: preset HI=0x11, LO=0x22 via mthi/mtlo, then div with B=0. Busy runs 10 cycles; HI=0x11, LO=0x22 afterwards.
- Stall and ignore checks:
  - D_md=1 held during a mult: md_stall=1 in cycle t and t+1..t+5, 0 at t+6.
  - A start with mtlo, A=0x55, during busy leaves LO unchanged.
- Reset during a div at cycle t+4: busy=0 and HI=LO=0 immediately. A following mult with A=B=3 gives LO=9 after 5 cycles.
